// File: rtl/spi_txn_pkg.sv
// Shared opcodes, header field offsets and FSM encoding for the SPI frame scheduler.
package spi_txn_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_RESP  = 4'hA;

  localparam int HDR_OP_LSB  = 12;
  localparam int HDR_CH_LSB  = 8;
  localparam int HDR_TAG_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  // RESP is transmit-only, so a master sending it is treated as an error.
  function automatic logic rx_op_ok(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/spi_slave_txn_ctrl_if.sv
// Bundle between the frame scheduler, spi_slave and the per-channel user logic.
interface spi_slave_txn_ctrl_if #(
  parameter int HEADER_WIDTH  = 16,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int N_CH          = 4
);
  logic                            spi_cs_n;
  logic [HEADER_WIDTH+PAYLOAD_WIDTH-1:0] rx_data;
  logic                            rx_header_valid;
  logic                            rx_payload_valid;
  logic                            tx_ready;
  logic [HEADER_WIDTH+PAYLOAD_WIDTH-1:0] tx_data;
  logic                            tx_send;
  logic [N_CH-1:0]                 ch_req;
  logic [N_CH*PAYLOAD_WIDTH-1:0]   ch_req_payload;
  logic [N_CH-1:0]                 ch_grant;
  logic [N_CH-1:0]                 ch_wr_valid;
  logic [PAYLOAD_WIDTH-1:0]        ch_wr_payload;
  logic                            hdr_err;

  modport slave (
    input  spi_cs_n, rx_data, rx_header_valid, rx_payload_valid, tx_ready,
    input  ch_req, ch_req_payload,
    output tx_data, tx_send, ch_grant, ch_wr_valid, ch_wr_payload, hdr_err
  );

  modport master (
    output spi_cs_n, rx_data, rx_header_valid, rx_payload_valid, tx_ready,
    output ch_req, ch_req_payload,
    input  tx_data, tx_send, ch_grant, ch_wr_valid, ch_wr_payload, hdr_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first set request at or after i_ptr wins.
module rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [N_CH-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  localparam int SW = IW + 1;

  always_comb begin
    logic [SW-1:0] w_sum;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_sum = {1'b0, i_ptr} + SW'(k);
      if (w_sum >= SW'(N_CH)) w_sum = w_sum - SW'(N_CH);
      if (!o_any && i_req[w_sum[IW-1:0]]) begin
        o_any                 = 1'b1;
        o_gnt[w_sum[IW-1:0]] = 1'b1;
        o_idx                 = w_sum[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/spi_slave_txn_ctrl.sv
// Schedules response frames into spi_slave only while CS is idle (ch_req to tx_send 2 clk)
// and decodes received headers into per-channel write pulses (1 clk after rx_payload_valid).
module spi_slave_txn_ctrl
  import spi_txn_pkg::*;
#(
  parameter int HEADER_WIDTH  = 16,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int N_CH          = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_slave_txn_ctrl_if.slave bus
);
  localparam int FW = HEADER_WIDTH + PAYLOAD_WIDTH;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

  logic                     r_cs_meta, r_cs_sync;
  state_t                   r_state;
  logic [IW-1:0]            r_win_idx, r_rr_ptr;
  logic [N_CH-1:0]          r_win_gnt, r_ch_grant;
  logic [7:0]               r_tag_cnt;
  logic [FW-1:0]            r_tx_data;
  logic                     r_tx_send;
  logic [N_CH-1:0]          r_wr_vld;
  logic [PAYLOAD_WIDTH-1:0] r_wr_payload;
  logic                     r_hdr_err;
  logic                     r_rx_hdr_vld;

  logic                     w_cs_idle;
  logic [N_CH-1:0]          w_gnt;
  logic [IW-1:0]            w_idx;
  logic                     w_any;
  logic [IW-1:0]            w_ptr_next;
  logic [PAYLOAD_WIDTH-1:0] w_win_payload;
  logic [FW-1:0]            w_nop_frame;
  logic [3:0]               w_rx_op, w_rx_ch;
  logic                     w_unused_dbg;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req (bus.ch_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_cs_idle   = r_cs_sync;
  assign w_ptr_next  = (r_win_idx == IW'(N_CH - 1)) ? '0 : r_win_idx + 1'b1;
  assign w_nop_frame = {OP_NOP, 4'h0, r_tag_cnt, {PAYLOAD_WIDTH{1'b0}}};
  assign w_rx_op     = bus.rx_data[PAYLOAD_WIDTH+HDR_OP_LSB +: 4];
  assign w_rx_ch     = bus.rx_data[PAYLOAD_WIDTH+HDR_CH_LSB +: 4];
  // The received tag and the header strobe are kept for waveform debug only.
  assign w_unused_dbg = ^{r_rx_hdr_vld, bus.rx_data[PAYLOAD_WIDTH+HDR_TAG_LSB +: 8]};

  always_comb begin
    w_win_payload = bus.ch_req_payload[PAYLOAD_WIDTH-1:0];
    for (int k = 1; k < N_CH; k++) begin
      if (r_win_idx == IW'(k)) w_win_payload = bus.ch_req_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
    end else begin
      r_cs_meta <= bus.spi_cs_n;
      r_cs_sync <= r_cs_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_win_idx  <= '0;
      r_win_gnt  <= '0;
      r_rr_ptr   <= '0;
      r_tag_cnt  <= 8'h00;
      r_tx_data  <= '0;
      r_tx_send  <= 1'b0;
      r_ch_grant <= '0;
    end else begin
      r_tx_send  <= 1'b0;
      r_ch_grant <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_idle && bus.tx_ready && w_any) begin
            r_win_idx <= w_idx;
            r_win_gnt <= w_gnt;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A requester that withdrew between arbitration and load is skipped.
          if (bus.ch_req[r_win_idx]) begin
            r_tx_data  <= {OP_RESP, 4'(r_win_idx), r_tag_cnt, w_win_payload};
            r_tx_send  <= 1'b1;
            r_ch_grant <= r_win_gnt;
            r_rr_ptr   <= w_ptr_next;
            r_tag_cnt  <= r_tag_cnt + 8'd1;
            r_state    <= ST_ARMED;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (!w_cs_idle) r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.rx_payload_valid || w_cs_idle) begin
            r_tx_data <= w_nop_frame;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vld     <= '0;
      r_wr_payload <= '0;
      r_hdr_err    <= 1'b0;
      r_rx_hdr_vld <= 1'b0;
    end else begin
      r_wr_vld     <= '0;
      r_hdr_err    <= 1'b0;
      r_rx_hdr_vld <= bus.rx_header_valid;
      if (bus.rx_payload_valid) begin
        if (!rx_op_ok(w_rx_op) || (int'(w_rx_ch) >= N_CH)) begin
          r_hdr_err <= 1'b1;
        end else if (w_rx_op == OP_WRITE) begin
          r_wr_vld     <= ONE_HOT0 << w_rx_ch;
          r_wr_payload <= bus.rx_data[PAYLOAD_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.tx_data       = r_tx_data;
  assign bus.tx_send       = r_tx_send;
  assign bus.ch_grant      = r_ch_grant;
  assign bus.ch_wr_valid   = r_wr_vld;
  assign bus.ch_wr_payload = r_wr_payload;
  assign bus.hdr_err       = r_hdr_err;
endmodule
